run_arbiter: RTL and testbench

Shares one start/stop-controlled run engine among N requesters. It arbitrates round-robin, issues a one-cycle start pulse to the engine, and monitors the session. It ends the session on owner release or timeout by issuing a one-cycle stop pulse, then enforces a cooldown before the next grant. It sits between requester blocks and the engine's start/stop inputs.

---
 rtl/run_arbiter.sv | 133 +++++++++++++
 tb/tb_run_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/run_arbiter.sv
// Round-robin arbiter that hands one start/stop run engine to N requesters,
// bounds every session with a timeout and spaces sessions with a cooldown.
module run_arbiter #(
  parameter int N        = 4,
  parameter int TIMEOUT  = 16,
  parameter int COOLDOWN = 2,
  localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          start,
  output logic          stop,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int KW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [KW-1:0] COOL_LAST = (COOLDOWN > 0) ? KW'(COOLDOWN - 1) : '0;
  localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_COOL
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [KW-1:0] ccnt;

  logic          found;
  logic [OW-1:0] sel;
  logic [OW:0]   sum;
  logic [OW-1:0] next_ptr;

  // Scan ptr, ptr+1, ... wrapping at N; the first set request wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (OW+1)'(i);
      if (sum >= (OW+1)'(N)) sum = sum - (OW+1)'(N);
      if (!found && req[sum[OW-1:0]]) begin
        found = 1'b1;
        sel   = sum[OW-1:0];
      end
    end
  end

  assign next_ptr = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      start       <= 1'b0;
      stop        <= 1'b0;
      busy        <= 1'b0;
      owner       <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      ccnt        <= '0;
    end else begin
      start       <= 1'b0;
      stop        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_START;
            owner <= sel;
            grant <= ONE << sel;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          state <= S_RUN;
          cnt   <= '0;
        end
        S_RUN: begin
          // Release is tested first so a simultaneous timeout is not flagged.
          if (!req[owner]) begin
            state <= S_STOP;
            stop  <= 1'b1;
            grant <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= S_STOP;
            stop        <= 1'b1;
            timeout_err <= 1'b1;
            grant       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          ptr  <= next_ptr;
          ccnt <= '0;
          if (COOLDOWN > 0) begin
            state <= S_COOL;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_COOL: begin
          if (ccnt == COOL_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_arbiter.sv
// Directed bench for run_arbiter: start/stop events are checked by a monitor
// against an expected queue of {kind, timeout_err, owner, grant, cycle} records.
module tb_run_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  int cyc   = 0;
  int epoch = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] grant0, grant1;
  logic         start0, start1, stop0, stop1, busy0, busy1, terr0, terr1;
  logic [1:0]   owner0, owner1;

  run_arbiter #(.N(N), .TIMEOUT(TO), .COOLDOWN(2)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant0), .start(start0),
    .stop(stop0), .busy(busy0), .owner(owner0), .timeout_err(terr0)
  );

  run_arbiter #(.N(N), .TIMEOUT(TO), .COOLDOWN(0)) dut_nocool (
    .clk(clk), .rst(rst), .req(req), .grant(grant1), .start(start1),
    .stop(stop1), .busy(busy1), .owner(owner1), .timeout_err(terr1)
  );

  logic [N-1:0] m_grant;
  logic         m_start, m_stop, m_busy, m_terr;
  logic [1:0]   m_owner;
  assign m_grant = sel ? grant1 : grant0;
  assign m_start = sel ? start1 : start0;
  assign m_stop  = sel ? stop1  : stop0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_owner = sel ? owner1 : owner0;
  assign m_terr  = sel ? terr1  : terr0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - epoch);
  endtask

  task automatic expect_start(input int o, input int c);
    exp_q.push_back({1'b0, 1'b0, 2'(o), 4'(1 << o), 8'(c)});
  endtask

  task automatic expect_stop(input int o, input logic terr, input int c);
    exp_q.push_back({1'b1, terr, 2'(o), 4'b0000, 8'(c)});
  endtask

  // Monitor: per-cycle invariants plus one queue pop per start/stop pulse.
  always @(negedge clk) begin
    logic [W-1:0] act;
    check("grant_onehot0", 32'($onehot0(m_grant)), 32'd1);
    check("start_stop_excl", 32'(m_start & m_stop), 32'd0);
    if (m_terr) check("terr_with_stop", 32'(m_stop), 32'd1);
    if (m_start || m_stop) begin
      act = {m_stop, m_terr, m_owner, m_grant, 8'(cyc - epoch)};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got 0x%0h expected none", act);
      end else begin
        check("event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_cycle(input int c);
    while ((cyc - epoch) < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test(input logic [N-1:0] r);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req   = r;
    epoch = cyc;
    check("reset_state", 32'({m_grant, m_start, m_stop, m_busy, m_owner, m_terr}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    // Test 1: single requester, released after three RUN cycles.
    start_test(4'b0001);
    expect_start(0, 1);
    expect_stop(0, 1'b0, 5);
    for (int k = 1; k <= 4; k++) begin
      to_cycle(k);
      check("t1_grant", 32'(m_grant), 32'h1);
    end
    req = '0;
    to_cycle(7);
    check("t1_busy_cool", 32'(m_busy), 32'd1);
    to_cycle(8);
    check("t1_busy_idle", 32'(m_busy), 32'd0);

    // Test 2: timeout after 8 RUN cycles, then re-grant of the sole requester.
    start_test(4'b0100);
    expect_start(2, 1);
    expect_stop(2, 1'b1, 10);
    expect_start(2, 14);
    expect_stop(2, 1'b0, 16);
    to_cycle(11);
    check("t2_grant_cool", 32'(m_grant), 32'd0);
    to_cycle(13);
    check("t2_owner_hold", 32'(m_owner), 32'd2);
    check("t2_idle", 32'(m_busy), 32'd0);
    to_cycle(15);
    req = '0;
    to_cycle(20);

    // Test 3: all requesting, each owner releases after two RUN cycles.
    start_test(4'b1111);
    for (int s = 0; s < 5; s++) begin
      expect_start(s % 4, 1 + 7 * s);
      expect_stop(s % 4, 1'b0, 4 + 7 * s);
    end
    for (int s = 0; s < 5; s++) begin
      to_cycle(3 + 7 * s);
      req = req & ~(4'(1 << (s % 4)));
      to_cycle(4 + 7 * s);
      req = req | 4'(1 << (s % 4));
    end
    req = '0;
    to_cycle(36);

    // Test 4: release on the same cycle the timeout would fire.
    start_test(4'b0010);
    expect_start(1, 1);
    expect_stop(1, 1'b0, 10);
    to_cycle(9);
    req = '0;
    to_cycle(13);
    check("t4_idle", 32'(m_busy), 32'd0);

    // Test 5: reset mid-RUN, then ptr restarts at 0.
    start_test(4'b0010);
    expect_start(1, 1);
    to_cycle(4);
    check("t5_run_grant", 32'(m_grant), 32'h2);
    rst = 1'b1;
    to_cycle(5);
    check("t5_reset_outputs", 32'({m_grant, m_start, m_stop, m_busy, m_owner, m_terr}), 32'd0);
    rst   = 1'b0;
    req   = 4'b1010;
    epoch = cyc;
    expect_start(1, 1);
    expect_stop(1, 1'b0, 3);
    to_cycle(1);
    req = '0;
    to_cycle(7);

    // Test 6: no cooldown, STOP goes straight to IDLE.
    sel = 1'b1;
    start_test(4'b0011);
    expect_start(0, 1);
    expect_stop(0, 1'b0, 3);
    expect_start(1, 5);
    expect_stop(1, 1'b0, 7);
    to_cycle(2);
    req = 4'b0010;
    to_cycle(4);
    check("t6_idle_after_stop", 32'(m_busy), 32'd0);
    to_cycle(6);
    req = '0;
    to_cycle(9);
    check("t6_idle_end", 32'(m_busy), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
